// File: rtl/vdiv_arbiter.sv
// Round-robin arbiter/sequencer sharing one FP divider between NUM_REQ requesters.
// One op in flight: IDLE grants, ISSUE pulses div_en, WAIT watches done/watchdog, RESP holds the result.

module vdiv_arb_lane (
  input  logic gnt,
  input  logic own,
  input  logic accept_en,
  input  logic resp_en,
  input  logic rdy,
  output logic req_ready,
  output logic resp_valid,
  output logic resp_hs
);
  assign req_ready  = accept_en & gnt;
  assign resp_valid = resp_en & own;
  assign resp_hs    = resp_valid & rdy;
endmodule

module vdiv_arbiter #(
  parameter int EXP_WIDTH  = 5,
  parameter int MANT_WIDTH = 10,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64,
  localparam int DW = EXP_WIDTH + MANT_WIDTH + 1,
  localparam int PW = $clog2(NUM_REQ),
  localparam int CW = $clog2(TIMEOUT)
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ-1:0][DW-1:0]   req_a,
  input  logic [NUM_REQ-1:0][DW-1:0]   req_b,
  output logic [NUM_REQ-1:0]           resp_valid,
  input  logic [NUM_REQ-1:0]           resp_ready,
  output logic [DW-1:0]                resp_result,
  output logic                         resp_err,
  output logic                         div_en,
  output logic [DW-1:0]                div_a,
  output logic [DW-1:0]                div_b,
  input  logic                         div_done,
  input  logic [DW-1:0]                div_result,
  output logic                         busy,
  output logic                         spurious_done
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  typedef struct packed {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  typedef struct packed {
    logic [DW-1:0] result;
    logic          err;
  } rsp_t;

  state_t             state, state_nx;
  op_t                op;
  rsp_t               rsp;
  logic [PW-1:0]      rr_ptr, owner, gnt_idx, rr_nx;
  logic               gnt_any;
  logic [CW-1:0]      wcnt;
  logic               limit;
  logic [NUM_REQ-1:0] gnt_oh, own_oh, hs;
  logic               accept_en, in_resp, resp_hs, spur_q;

  // First pending requester at or above rr_ptr, wrapping around.
  always_comb begin
    int            k;
    logic [PW-1:0] idx;
    gnt_any = 1'b0;
    gnt_idx = '0;
    k       = 0;
    idx     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(rr_ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      idx = PW'(k);
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    own_oh = '0;
    if (gnt_any) gnt_oh[gnt_idx] = 1'b1;
    own_oh[owner] = 1'b1;
  end

  assign rr_nx     = (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + PW'(1);
  assign limit     = (wcnt == CW'(TIMEOUT - 2));
  assign accept_en = (state == IDLE) & gnt_any & ~RST;
  assign in_resp   = (state == RESP) & ~RST;

  vdiv_arb_lane u_lane [NUM_REQ-1:0] (
    .gnt        (gnt_oh),
    .own        (own_oh),
    .accept_en  (accept_en),
    .resp_en    (in_resp),
    .rdy        (resp_ready),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_hs    (hs)
  );

  assign resp_hs = |hs;

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gnt_any) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (div_done || limit) state_nx = RESP;
      RESP:    if (resp_hs) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      op     <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      wcnt   <= '0;
      rsp    <= '0;
      spur_q <= 1'b0;
    end else begin
      if (accept_en) begin
        op.a   <= req_a[gnt_idx];
        op.b   <= req_b[gnt_idx];
        owner  <= gnt_idx;
        rr_ptr <= rr_nx;
      end
      if (state == ISSUE) wcnt <= '0;
      else if (state == WAIT && !div_done && !limit) wcnt <= wcnt + CW'(1);
      // done on the limit cycle is still a normal completion
      if (state == WAIT) begin
        if (div_done) begin
          rsp.result <= div_result;
          rsp.err    <= 1'b0;
        end else if (limit) begin
          rsp.result <= '0;
          rsp.err    <= 1'b1;
        end
      end
      if (div_done && state != WAIT) spur_q <= 1'b1;
    end
  end

  assign div_en        = (state == ISSUE) & ~RST;
  assign div_a         = op.a;
  assign div_b         = op.b;
  assign resp_result   = rsp.result;
  assign resp_err      = rsp.err;
  assign busy          = (state != IDLE);
  assign spurious_done = spur_q;

endmodule

// File: tb/tb_vdiv_arbiter.sv
// Directed bench for vdiv_arbiter with a latency-programmable divider model.
module tb_vdiv_arbiter;
  localparam int NR = 4;
  localparam int DW = 16;

  logic                    CLK = 1'b0;
  logic                    RST = 1'b1;
  logic [NR-1:0]           req_valid = '0;
  logic [NR-1:0]           req_ready;
  logic [NR-1:0][DW-1:0]   req_a = '0;
  logic [NR-1:0][DW-1:0]   req_b = '0;
  logic [NR-1:0]           resp_valid;
  logic [NR-1:0]           resp_ready = '0;
  logic [DW-1:0]           resp_result;
  logic                    resp_err;
  logic                    div_en;
  logic [DW-1:0]           div_a, div_b;
  logic                    div_done = 1'b0;
  logic [DW-1:0]           div_result = '0;
  logic                    busy;
  logic                    spurious_done;

  int            total = 0;
  int            bad = 0;
  int            lat = 1;
  int            cd = 0;
  logic          model_on = 1'b0;
  logic [DW-1:0] dres = '0;

  vdiv_arbiter dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_result(resp_result), .resp_err(resp_err),
    .div_en(div_en), .div_a(div_a), .div_b(div_b),
    .div_done(div_done), .div_result(div_result),
    .busy(busy), .spurious_done(spurious_done)
  );

  always #5 CLK = ~CLK;

  // Advance to the next falling edge; the divider model answers `lat` cycles after div_en.
  task automatic tick();
    @(negedge CLK);
    div_done   = 1'b0;
    div_result = 16'hDEAD;
    if (cd > 0) begin
      cd = cd - 1;
      if (cd == 0) begin
        div_done   = 1'b1;
        div_result = dres;
      end
    end
    if (div_en && model_on) cd = lat;
  endtask

  task automatic test_reset();
    logic [70:0] outs;
    RST = 1'b1;
    tick(); tick();
    outs = {req_ready, resp_valid, resp_result, resp_err, div_en, div_a, div_b, busy, spurious_done};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_hold: got %h want 0", outs); end
    RST = 1'b0;
    tick();
    outs = {req_ready, resp_valid, resp_result, resp_err, div_en, div_a, div_b, busy, spurious_done};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_release: got %h want 0", outs); end
  endtask

  task automatic test_fairness();
    logic [NR-1:0] exp_g [5];
    logic [NR-1:0] last;
    int n;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    n = 0; last = '0;
    lat = 1; model_on = 1'b1; dres = 16'h1234;
    resp_ready = 4'hF;
    req_valid  = 4'hF;
    for (int c = 0; c < 100 && n < 5; c++) begin
      #1;
      if (resp_valid !== '0) begin
        total++;
        if (resp_valid !== last) begin bad++; $display("FAIL fair_resp_owner: got %b want %b", resp_valid, last); end
      end
      if (req_ready !== '0) begin
        total++;
        if (req_ready !== exp_g[n]) begin bad++; $display("FAIL fair_grant%0d: got %b want %b", n, req_ready, exp_g[n]); end
        last = req_ready;
        n++;
      end
      if (n < 5) tick();
    end
    total++;
    if (n != 5) begin bad++; $display("FAIL fair_count: got %0d want 5", n); end
    tick();
    req_valid = '0;
    for (int c = 0; c < 20 && busy; c++) tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL fair_drain: busy got %b want 0", busy); end
    resp_ready = '0;
  endtask

  task automatic test_single();
    req_a[1] = 16'h3C00; req_b[1] = 16'h4000;
    lat = 3; dres = 16'h3800; model_on = 1'b1; resp_ready = '0;
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0010 || div_en !== 1'b0) begin bad++; $display("FAIL single_accept: got rdy=%b en=%b want 0010/0", req_ready, div_en); end
    tick();
    req_valid = '0;
    total++;
    if (div_en !== 1'b1 || div_a !== 16'h3C00 || div_b !== 16'h4000) begin
      bad++; $display("FAIL single_issue: got en=%b a=%h b=%h want 1/3c00/4000", div_en, div_a, div_b);
    end
    for (int k = 2; k <= 4; k++) begin
      tick();
      total++;
      if ({div_en, resp_valid} !== 5'b0) begin bad++; $display("FAIL single_wait%0d: got en=%b rv=%b want 0", k, div_en, resp_valid); end
    end
    tick();
    total++;
    if (resp_valid !== 4'b0010 || resp_result !== 16'h3800 || resp_err !== 1'b0) begin
      bad++; $display("FAIL single_resp: got rv=%b r=%h e=%b want 0010/3800/0", resp_valid, resp_result, resp_err);
    end
    resp_ready = 4'b1101;
    tick();
    total++;
    if (resp_valid !== 4'b0010 || resp_result !== 16'h3800) begin bad++; $display("FAIL single_other_ready: got rv=%b r=%h want 0010/3800", resp_valid, resp_result); end
    resp_ready = '0;
    tick();
    total++;
    if (resp_valid !== 4'b0010 || resp_result !== 16'h3800) begin bad++; $display("FAIL single_hold: got rv=%b r=%h want 0010/3800", resp_valid, resp_result); end
    resp_ready = 4'b0010;
    tick();
    total++;
    if (busy !== 1'b0 || resp_valid !== 4'b0) begin bad++; $display("FAIL single_done: got busy=%b rv=%b want 0/0000", busy, resp_valid); end
    resp_ready = '0;
  endtask

  task automatic test_backpressure();
    logic seen;
    req_a[2] = 16'h4400; req_b[2] = 16'h4000;
    lat = 2; dres = 16'h4000; model_on = 1'b1; resp_ready = '0;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL bp_accept: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      tick();
      if (resp_valid !== '0) seen = 1'b1;
    end
    total++;
    if (!seen) begin bad++; $display("FAIL bp_resp_timeout: got none want resp_valid"); end
    req_valid = 4'b1011;
    for (int k = 0; k < 10; k++) begin
      #1;
      total++;
      if ({resp_valid, resp_result, req_ready, div_en} !== {4'b0100, 16'h4000, 4'b0000, 1'b0}) begin
        bad++; $display("FAIL bp_stall%0d: got rv=%b r=%h rdy=%b en=%b want 0100/4000/0000/0", k, resp_valid, resp_result, req_ready, div_en);
      end
      tick();
    end
    resp_ready = 4'b0100;
    tick();
    #1;
    total++;
    if (busy !== 1'b0 || req_ready !== 4'b1000) begin bad++; $display("FAIL bp_release: got busy=%b rdy=%b want 0/1000", busy, req_ready); end
    tick();
    req_valid = '0;
    resp_ready = 4'hF;
    for (int c = 0; c < 20 && busy; c++) tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL bp_drain: busy got %b want 0", busy); end
    resp_ready = '0;
  endtask

  task automatic test_timeout();
    model_on = 1'b0;
    req_a[0] = 16'h7BFF; req_b[0] = 16'h0000;
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL to_accept: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    total++;
    if (div_en !== 1'b1) begin bad++; $display("FAIL to_issue: got %b want 1", div_en); end
    for (int k = 1; k <= 63; k++) begin
      tick();
      total++;
      if (resp_valid !== 4'b0) begin bad++; $display("FAIL to_early%0d: got %b want 0000", k, resp_valid); end
    end
    tick();
    total++;
    if (resp_valid !== 4'b0001 || resp_err !== 1'b1 || resp_result !== 16'h0000) begin
      bad++; $display("FAIL to_resp: got rv=%b e=%b r=%h want 0001/1/0000", resp_valid, resp_err, resp_result);
    end
    resp_ready = 4'b0001;
    tick();
    resp_ready = '0;
    total++;
    if (busy !== 1'b0 || spurious_done !== 1'b0) begin bad++; $display("FAIL to_idle: got busy=%b sp=%b want 0/0", busy, spurious_done); end
    div_done = 1'b1; div_result = 16'h1111;
    tick();
    total++;
    if (spurious_done !== 1'b1 || busy !== 1'b0 || resp_valid !== 4'b0) begin
      bad++; $display("FAIL to_spurious: got sp=%b busy=%b rv=%b want 1/0/0000", spurious_done, busy, resp_valid);
    end
  endtask

  task automatic test_coincident();
    model_on = 1'b1; lat = 63; dres = 16'h4200;
    req_a[1] = 16'h4800; req_b[1] = 16'h3E00;
    req_valid = 4'b0010;
    #1;
    total++;
    if (req_ready !== 4'b0010) begin bad++; $display("FAIL co_accept: got %b want 0010", req_ready); end
    tick();
    req_valid = '0;
    total++;
    if (div_en !== 1'b1) begin bad++; $display("FAIL co_issue: got %b want 1", div_en); end
    for (int k = 1; k <= 63; k++) begin
      tick();
      total++;
      if (resp_valid !== 4'b0) begin bad++; $display("FAIL co_early%0d: got %b want 0000", k, resp_valid); end
    end
    tick();
    total++;
    if (resp_valid !== 4'b0010 || resp_err !== 1'b0 || resp_result !== 16'h4200) begin
      bad++; $display("FAIL co_resp: got rv=%b e=%b r=%h want 0010/0/4200", resp_valid, resp_err, resp_result);
    end
    resp_ready = 4'b0010;
    tick();
    resp_ready = '0;
    total++;
    if (busy !== 1'b0 || spurious_done !== 1'b1) begin bad++; $display("FAIL co_sticky: got busy=%b sp=%b want 0/1", busy, spurious_done); end
  endtask

  task automatic test_reset_mid();
    logic [70:0] outs;
    model_on = 1'b0;
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin bad++; $display("FAIL rm_accept: got %b want 0100", req_ready); end
    tick();
    req_valid = '0;
    tick(); tick(); tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL rm_busy: got %b want 1", busy); end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    outs = {req_ready, resp_valid, resp_result, resp_err, div_en, div_a, div_b, busy, spurious_done};
    total++;
    if (outs !== '0) begin bad++; $display("FAIL rm_clear: got %h want 0", outs); end
    div_done = 1'b1; div_result = 16'h2222;
    tick();
    total++;
    if (spurious_done !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL rm_late_done: got sp=%b busy=%b want 1/0", spurious_done, busy); end
    model_on = 1'b1; lat = 1; resp_ready = 4'hF;
    req_valid = 4'b1001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL rm_ptr: got %b want 0001", req_ready); end
    tick();
    req_valid = '0;
    for (int c = 0; c < 20 && busy; c++) tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL rm_drain: busy got %b want 0", busy); end
    resp_ready = '0;
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_backpressure();
    test_timeout();
    test_coincident();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
